// File: rtl/avst_fifo.sv
// Purpose: single-clock Avalon-ST FIFO; optional frame mode commits on EOP and drops bad/oversize frames.
// Latency: beat accepted at edge N (frame mode: EOP commit edge) drives avst_out_valid at edge N+PIPELINE_OUTPUT+1.
// Backpressure: avst_in_ready = !full (held high while dropping, always high with DROP_WHEN_FULL); output holds while !avst_out_ready.
//
// Ports: clk / rst (async, active-low); avst_in_* sink beat with valid/ready;
//        avst_out_* source beat with valid/ready; status_* one-cycle frame event pulses.
module avst_fifo #(
    parameter int DEPTH                 = 4096,
    parameter int DATA_WIDTH            = 8,
    parameter int EMPTY_ENABLE          = 1,
    parameter int EMPTY_WIDTH           = $clog2(DATA_WIDTH/8+1),
    parameter int SOP_ENABLE            = 1,
    parameter int EOP_ENABLE            = 1,
    parameter int CHANNEL_ENABLE        = 0,
    parameter int CHANNEL_WIDTH         = 8,
    parameter int ERROR_ENABLE          = 0,
    parameter int ERROR_WIDTH           = 1,
    parameter int PIPELINE_OUTPUT       = 2,
    parameter int FRAME_FIFO            = 0,
    parameter int ERROR_BAD_FRAME_VALUE = 1,
    parameter int ERROR_BAD_FRAME_MASK  = 1,
    parameter int DROP_OVERSIZE_FRAME   = FRAME_FIFO,
    parameter int DROP_BAD_FRAME        = 0,
    parameter int DROP_WHEN_FULL        = 0
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [DATA_WIDTH-1:0]    avst_in_data,
    input  logic [EMPTY_WIDTH-1:0]   avst_in_empty,
    input  logic                     avst_in_valid,
    output logic                     avst_in_ready,
    input  logic                     avst_in_startofpacket,
    input  logic                     avst_in_endofpacket,
    input  logic [CHANNEL_WIDTH-1:0] avst_in_channel,
    input  logic [ERROR_WIDTH-1:0]   avst_in_error,

    output logic [DATA_WIDTH-1:0]    avst_out_data,
    output logic [EMPTY_WIDTH-1:0]   avst_out_empty,
    output logic                     avst_out_valid,
    input  logic                     avst_out_ready,
    output logic                     avst_out_startofpacket,
    output logic                     avst_out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] avst_out_channel,
    output logic [ERROR_WIDTH-1:0]   avst_out_error,

    output logic                     status_overflow,
    output logic                     status_bad_frame,
    output logic                     status_good_frame
);

    localparam int AW        = $clog2(DEPTH);
    localparam int P         = PIPELINE_OUTPUT;
    localparam int EMPTY_OFF = DATA_WIDTH;
    localparam int SOP_OFF   = EMPTY_OFF + ((EMPTY_ENABLE != 0) ? EMPTY_WIDTH : 0);
    localparam int EOP_OFF   = SOP_OFF + ((SOP_ENABLE != 0) ? 1 : 0);
    localparam int CH_OFF    = EOP_OFF + ((EOP_ENABLE != 0) ? 1 : 0);
    localparam int ERR_OFF   = CH_OFF + ((CHANNEL_ENABLE != 0) ? CHANNEL_WIDTH : 0);
    localparam int WORD_W    = ERR_OFF + ((ERROR_ENABLE != 0) ? ERROR_WIDTH : 0);

    // Pointer distance of exactly DEPTH: only the wrap bit differs.
    localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] BAD_MASK  = ERROR_WIDTH'(ERROR_BAD_FRAME_MASK);
    localparam logic [ERROR_WIDTH-1:0] BAD_VALUE = ERROR_WIDTH'(ERROR_BAD_FRAME_VALUE);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [AW:0]  wr_ptr;          // working write pointer
    logic [AW:0]  wr_ptr_commit;   // last committed beat boundary
    logic [AW:0]  rd_commit_ptr;   // commit pointer as seen by the read side, one cycle later
    logic [AW:0]  rd_ptr;
    logic [AW:0]  frame_len;
    logic         drop_frame;
    logic         run;             // holds ready low until the first edge after reset
    logic         full, full_cur, rd_empty;
    logic         wr_en, mem_we, drop_beat, bad_frame, rd_en;
    logic         ovf_q, bad_q, good_q;

    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] out_word;
    logic [WORD_W-1:0] pipe_word [P];
    logic [P-1:0]      pipe_vld;
    logic [P-1:0]      stage_rdy;

    // Pack only the enabled sideband fields into the RAM word.
    assign wr_word[DATA_WIDTH-1:0] = avst_in_data;
    if (EMPTY_ENABLE != 0) begin : g_empty_in
        assign wr_word[EMPTY_OFF +: EMPTY_WIDTH] = avst_in_empty;
    end
    if (SOP_ENABLE != 0) begin : g_sop_in
        assign wr_word[SOP_OFF] = avst_in_startofpacket;
    end
    if (EOP_ENABLE != 0) begin : g_eop_in
        assign wr_word[EOP_OFF] = avst_in_endofpacket;
    end
    if (CHANNEL_ENABLE != 0) begin : g_ch_in
        assign wr_word[CH_OFF +: CHANNEL_WIDTH] = avst_in_channel;
    end
    if (ERROR_ENABLE != 0) begin : g_err_in
        assign wr_word[ERR_OFF +: ERROR_WIDTH] = avst_in_error;
    end

    assign frame_len = wr_ptr - wr_ptr_commit;
    assign full      = (wr_ptr == (rd_ptr ^ PTR_MSB));
    assign full_cur  = (frame_len == PTR_MSB);
    assign rd_empty  = (rd_commit_ptr == rd_ptr);
    assign bad_frame = ((avst_in_error & BAD_MASK) == BAD_VALUE);

    // A beat is discarded (but still accepted) once the current frame can no
    // longer fit: either it already spans DEPTH beats, or the FIFO is full
    // and dropping is preferred over backpressure.
    assign drop_beat = (FRAME_FIFO != 0) && (DROP_OVERSIZE_FRAME != 0) &&
                       (drop_frame || full_cur || ((DROP_WHEN_FULL != 0) && full));

    assign avst_in_ready = run && (!full || (DROP_WHEN_FULL != 0) || drop_beat);
    assign wr_en         = avst_in_valid && avst_in_ready;
    assign mem_we        = wr_en && !drop_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            wr_ptr_commit <= '0;
            rd_commit_ptr <= '0;
            drop_frame    <= 1'b0;
            run           <= 1'b0;
            ovf_q         <= 1'b0;
            bad_q         <= 1'b0;
            good_q        <= 1'b0;
        end else begin
            run           <= 1'b1;
            ovf_q         <= 1'b0;
            bad_q         <= 1'b0;
            good_q        <= 1'b0;
            rd_commit_ptr <= wr_ptr_commit;
            if (wr_en) begin
                if (FRAME_FIFO == 0) begin
                    wr_ptr        <= wr_ptr + 1'b1;
                    wr_ptr_commit <= wr_ptr + 1'b1;
                end else if (drop_beat) begin
                    drop_frame <= 1'b1;
                    if (avst_in_endofpacket) begin
                        wr_ptr     <= wr_ptr_commit;
                        drop_frame <= 1'b0;
                        ovf_q      <= 1'b1;
                    end
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (avst_in_endofpacket) begin
                        if ((DROP_BAD_FRAME != 0) && bad_frame) begin
                            wr_ptr <= wr_ptr_commit;
                            bad_q  <= 1'b1;
                        end else begin
                            wr_ptr_commit <= wr_ptr + 1'b1;
                            good_q        <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    // Stage i may load when any stage at or after it is empty, or the
    // output beat is being consumed; bubbles collapse toward the output.
    always_comb begin
        stage_rdy = '0;
        for (int i = 0; i < P; i++) begin
            stage_rdy[i] = avst_out_ready;
            for (int j = i; j < P; j++) begin
                if (!pipe_vld[j]) begin
                    stage_rdy[i] = 1'b1;
                end
            end
        end
    end

    assign rd_en = !rd_empty && stage_rdy[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            pipe_vld <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (stage_rdy[0]) begin
                pipe_vld[0] <= rd_en;
            end
            for (int i = 1; i < P; i++) begin
                if (stage_rdy[i]) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            pipe_word[0] <= mem[rd_ptr[AW-1:0]];
        end
        for (int i = 1; i < P; i++) begin
            if (stage_rdy[i]) begin
                pipe_word[i] <= pipe_word[i-1];
            end
        end
    end

    assign out_word       = pipe_word[P-1];
    assign avst_out_valid = pipe_vld[P-1];
    assign avst_out_data  = out_word[DATA_WIDTH-1:0];

    // Fields that are not carried read back as fixed idle values.
    if (EMPTY_ENABLE != 0) begin : g_empty_out
        assign avst_out_empty = out_word[EMPTY_OFF +: EMPTY_WIDTH];
    end else begin : g_empty_out_off
        assign avst_out_empty = '0;
    end
    if (SOP_ENABLE != 0) begin : g_sop_out
        assign avst_out_startofpacket = out_word[SOP_OFF];
    end else begin : g_sop_out_off
        assign avst_out_startofpacket = 1'b0;
    end
    if (EOP_ENABLE != 0) begin : g_eop_out
        assign avst_out_endofpacket = out_word[EOP_OFF];
    end else begin : g_eop_out_off
        assign avst_out_endofpacket = 1'b1;
    end
    if (CHANNEL_ENABLE != 0) begin : g_ch_out
        assign avst_out_channel = out_word[CH_OFF +: CHANNEL_WIDTH];
    end else begin : g_ch_out_off
        assign avst_out_channel = '0;
    end
    if (ERROR_ENABLE != 0) begin : g_err_out
        assign avst_out_error = out_word[ERR_OFF +: ERROR_WIDTH];
    end else begin : g_err_out_off
        assign avst_out_error = '0;
    end

    assign status_overflow   = ovf_q;
    assign status_bad_frame  = bad_q;
    assign status_good_frame = good_q;

    // Inputs that some configurations never look at.
    logic unused_ok;
    assign unused_ok = ^{avst_in_empty, avst_in_startofpacket, avst_in_endofpacket,
                         avst_in_channel, avst_in_error, full_cur};

endmodule

// File: tb/tb_avst_fifo.sv
// Purpose: directed checks of avst_fifo in streaming mode and in frame mode.
// Latency: n/a (testbench).
// Backpressure: drives in_valid/out_ready patterns, including random stalls.
module tb_avst_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- streaming instance: DEPTH 16, one output stage ----------
    logic [15:0] nf_in_data;
    logic [1:0]  nf_in_empty;
    logic        nf_in_valid, nf_in_ready, nf_in_sop, nf_in_eop;
    logic [3:0]  nf_in_ch;
    logic [1:0]  nf_in_err;
    logic [15:0] nf_out_data;
    logic [1:0]  nf_out_empty;
    logic        nf_out_valid, nf_out_ready, nf_out_sop, nf_out_eop;
    logic [3:0]  nf_out_ch;
    logic [1:0]  nf_out_err;
    logic        nf_ovf, nf_bad, nf_good;

    avst_fifo #(
        .DEPTH(16), .DATA_WIDTH(16), .EMPTY_WIDTH(2),
        .CHANNEL_ENABLE(1), .CHANNEL_WIDTH(4),
        .ERROR_ENABLE(1), .ERROR_WIDTH(2),
        .PIPELINE_OUTPUT(1), .FRAME_FIFO(0)
    ) u_nf (
        .clk(clk), .rst(rst),
        .avst_in_data(nf_in_data), .avst_in_empty(nf_in_empty),
        .avst_in_valid(nf_in_valid), .avst_in_ready(nf_in_ready),
        .avst_in_startofpacket(nf_in_sop), .avst_in_endofpacket(nf_in_eop),
        .avst_in_channel(nf_in_ch), .avst_in_error(nf_in_err),
        .avst_out_data(nf_out_data), .avst_out_empty(nf_out_empty),
        .avst_out_valid(nf_out_valid), .avst_out_ready(nf_out_ready),
        .avst_out_startofpacket(nf_out_sop), .avst_out_endofpacket(nf_out_eop),
        .avst_out_channel(nf_out_ch), .avst_out_error(nf_out_err),
        .status_overflow(nf_ovf), .status_bad_frame(nf_bad), .status_good_frame(nf_good)
    );

    // ---------------- frame instance: DEPTH 16, two output stages -------------
    logic [7:0] fr_in_data;
    logic       fr_in_empty;
    logic       fr_in_valid, fr_in_ready, fr_in_sop, fr_in_eop;
    logic [7:0] fr_in_ch;
    logic       fr_in_err;
    logic [7:0] fr_out_data;
    logic       fr_out_empty;
    logic       fr_out_valid, fr_out_ready, fr_out_sop, fr_out_eop;
    logic [7:0] fr_out_ch;
    logic       fr_out_err;
    logic       fr_ovf, fr_bad, fr_good;

    avst_fifo #(
        .DEPTH(16), .DATA_WIDTH(8), .ERROR_ENABLE(1), .ERROR_WIDTH(1),
        .PIPELINE_OUTPUT(2), .FRAME_FIFO(1), .DROP_BAD_FRAME(1),
        .ERROR_BAD_FRAME_MASK(1), .ERROR_BAD_FRAME_VALUE(1)
    ) u_fr (
        .clk(clk), .rst(rst),
        .avst_in_data(fr_in_data), .avst_in_empty(fr_in_empty),
        .avst_in_valid(fr_in_valid), .avst_in_ready(fr_in_ready),
        .avst_in_startofpacket(fr_in_sop), .avst_in_endofpacket(fr_in_eop),
        .avst_in_channel(fr_in_ch), .avst_in_error(fr_in_err),
        .avst_out_data(fr_out_data), .avst_out_empty(fr_out_empty),
        .avst_out_valid(fr_out_valid), .avst_out_ready(fr_out_ready),
        .avst_out_startofpacket(fr_out_sop), .avst_out_endofpacket(fr_out_eop),
        .avst_out_channel(fr_out_ch), .avst_out_error(fr_out_err),
        .status_overflow(fr_ovf), .status_bad_frame(fr_bad), .status_good_frame(fr_good)
    );

    function automatic logic [31:0] nf_pack(input logic [15:0] d, input logic [1:0] e,
                                            input logic s, input logic eo,
                                            input logic [3:0] c, input logic [1:0] er);
        return {6'd0, d, e, s, eo, c, er};
    endfunction

    function automatic logic [31:0] fr_pack(input logic [7:0] c, input logic e, input logic er,
                                            input logic s, input logic eo, input logic [7:0] d);
        return {12'd0, c, e, er, s, eo, d};
    endfunction

    // ---------------- output monitor (samples on the falling edge) -----------
    logic [31:0] nf_q[$];
    logic [31:0] fr_q[$];
    int          nf_first_cyc = -1;
    int          fr_first_cyc = -1;
    int          fr_good_n = 0, fr_bad_n = 0, fr_ovf_n = 0;
    bit          stall_en = 1'b0;
    logic        nf_prev_stall = 1'b0;
    logic [31:0] nf_prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (nf_out_valid && nf_out_ready) begin
                nf_q.push_back(nf_pack(nf_out_data, nf_out_empty, nf_out_sop, nf_out_eop,
                                       nf_out_ch, nf_out_err));
                if (nf_first_cyc < 0) nf_first_cyc = cyc_n;
            end
            if (fr_out_valid && fr_out_ready) begin
                fr_q.push_back(fr_pack(fr_out_ch, fr_out_empty, fr_out_err, fr_out_sop,
                                       fr_out_eop, fr_out_data));
                if (fr_first_cyc < 0) fr_first_cyc = cyc_n;
            end
            if (stall_en && nf_prev_stall) begin
                chk("stall_vld", nf_out_valid, 1);
                chk("stall_dat", nf_pack(nf_out_data, nf_out_empty, nf_out_sop, nf_out_eop,
                                         nf_out_ch, nf_out_err), nf_prev_word);
            end
            nf_prev_stall = nf_out_valid && !nf_out_ready;
            nf_prev_word  = nf_pack(nf_out_data, nf_out_empty, nf_out_sop, nf_out_eop,
                                    nf_out_ch, nf_out_err);
            fr_good_n += int'(fr_good);
            fr_bad_n  += int'(fr_bad);
            fr_ovf_n  += int'(fr_ovf);
        end
    end

    // Frame-mode stimulus: A (3 beats), B (2 beats, bad on EOP), C (1 beat).
    logic [7:0] t4_dat [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hC1};
    logic       t4_sop [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       t4_eop [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       t4_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int acc_cyc;
        int n_acc;
        int n_in;
        int rdy_low;
        logic [31:0] w;

        nf_in_data = '0; nf_in_empty = '0; nf_in_valid = 0; nf_in_sop = 0; nf_in_eop = 0;
        nf_in_ch = '0; nf_in_err = '0; nf_out_ready = 0;
        fr_in_data = '0; fr_in_empty = 0; fr_in_valid = 0; fr_in_sop = 0; fr_in_eop = 0;
        fr_in_ch = 8'h5A; fr_in_err = 0; fr_out_ready = 0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        chk("rst_nf_vld", nf_out_valid, 0);
        chk("rst_nf_rdy", nf_in_ready, 0);
        chk("rst_fr_rdy", fr_in_ready, 0);
        chk("rst_fr_status", {fr_ovf, fr_bad, fr_good}, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_nf_rdy", nf_in_ready, 1);
        chk("rel_fr_rdy", fr_in_ready, 1);

        // ---- 5 beats through, sideband preserved, latency P+1 = 2 ----
        nf_out_ready = 1;
        acc_cyc = 0;
        for (int i = 1; i <= 5; i++) begin
            nf_in_valid = 1;
            nf_in_data  = 16'(i);
            nf_in_sop   = (i == 1);
            nf_in_eop   = (i == 5);
            nf_in_empty = 2'(i);
            nf_in_ch    = 4'(i + 3);
            nf_in_err   = 2'(i);
            if (i == 1) acc_cyc = cyc_n + 1;
            step();
        end
        nf_in_valid = 0; nf_in_sop = 0; nf_in_eop = 0;
        nf_in_empty = 0; nf_in_ch = 0; nf_in_err = 0;
        for (int c = 0; c < 50 && nf_q.size() < 5; c++) step();
        chk("t1_cnt", nf_q.size(), 5);
        chk("t1_lat", nf_first_cyc - acc_cyc, 2);
        for (int i = 1; i <= 5 && nf_q.size() > 0; i++) begin
            w = nf_q.pop_front();
            chk("t1_beat", w, nf_pack(16'(i), 2'(i), i == 1, i == 5, 4'(i + 3), 2'(i)));
        end

        // ---- fill: 16 RAM slots plus the one output stage hold 17 beats ----
        nf_out_ready = 0;
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            nf_in_valid = 1;
            nf_in_data  = 16'(100 + n_acc);
            if (nf_in_ready) n_acc++;
            step();
        end
        nf_in_valid = 0;
        chk("fill_cnt", n_acc, 17);
        chk("fill_rdy", nf_in_ready, 0);
        nf_out_ready = 1;
        step();
        nf_out_ready = 0;
        chk("fill_rdy_back", nf_in_ready, 1);
        nf_in_valid = 1;
        nf_in_data  = 16'(117);
        step();
        nf_in_valid = 0;
        nf_out_ready = 1;
        for (int c = 0; c < 100 && nf_q.size() < 18; c++) step();
        chk("fill_out_cnt", nf_q.size(), 18);
        for (int i = 0; i < 18 && nf_q.size() > 0; i++) begin
            w = nf_q.pop_front();
            chk("fill_beat", w, nf_pack(16'(100 + i), 0, 0, 0, 0, 0));
        end

        // ---- random valid / ready, 1000 beats, stalls must hold ----
        nf_q.delete();
        stall_en = 1'b1;
        n_in = 0;
        for (int c = 0; c < 20000 && nf_q.size() < 1000; c++) begin
            nf_in_valid  = (n_in < 1000) && ($urandom_range(3) != 0);
            nf_in_data   = 16'(n_in * 7 + 3);
            if (nf_in_valid && nf_in_ready) n_in++;
            nf_out_ready = ($urandom_range(3) != 0);
            step();
        end
        nf_in_valid = 0;
        stall_en = 1'b0;
        nf_out_ready = 1;
        chk("rnd_cnt", nf_q.size(), 1000);
        for (int i = 0; i < 1000 && nf_q.size() > 0; i++) begin
            w = nf_q.pop_front();
            chk("rnd_beat", w, nf_pack(16'(i * 7 + 3), 0, 0, 0, 0, 0));
        end

        // ---- frame mode: bad frame dropped, disabled channel reads 0 ----
        fr_out_ready = 1;
        acc_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            fr_in_valid = 1;
            fr_in_data  = t4_dat[i];
            fr_in_sop   = t4_sop[i];
            fr_in_eop   = t4_eop[i];
            fr_in_err   = t4_err[i];
            fr_in_empty = t4_eop[i];
            if (i == 2) acc_cyc = cyc_n + 1;
            step();
        end
        fr_in_valid = 0; fr_in_sop = 0; fr_in_eop = 0; fr_in_err = 0; fr_in_empty = 0;
        repeat (30) step();
        chk("fr_cnt", fr_q.size(), 4);
        chk("fr_lat", fr_first_cyc - acc_cyc, 3);
        for (int i = 0; i < 6; i++) begin
            if (i == 3 || i == 4) continue;
            if (fr_q.size() > 0) begin
                w = fr_q.pop_front();
                chk("fr_beat", w, fr_pack(8'h00, t4_eop[i], 1'b0, t4_sop[i], t4_eop[i], t4_dat[i]));
            end
        end
        chk("fr_good", fr_good_n, 2);
        chk("fr_bad", fr_bad_n, 1);
        chk("fr_ovf0", fr_ovf_n, 0);

        // ---- frame mode: 20-beat frame dropped, 4-beat frame kept ----
        fr_q.delete();
        rdy_low = 0;
        for (int i = 0; i < 24; i++) begin
            if (!fr_in_ready) rdy_low++;
            fr_in_valid = 1;
            fr_in_data  = (i < 20) ? 8'(32 + i) : 8'(64 + i - 20);
            fr_in_sop   = (i == 0) || (i == 20);
            fr_in_eop   = (i == 19) || (i == 23);
            step();
        end
        fr_in_valid = 0; fr_in_sop = 0; fr_in_eop = 0;
        repeat (30) step();
        chk("ovs_rdy_low", rdy_low, 0);
        chk("ovs_cnt", fr_q.size(), 4);
        for (int j = 0; j < 4 && fr_q.size() > 0; j++) begin
            w = fr_q.pop_front();
            chk("ovs_beat", w, fr_pack(8'h00, 1'b0, 1'b0, j == 0, j == 3, 8'(64 + j)));
        end
        chk("ovs_ovf", fr_ovf_n, 1);
        chk("ovs_good", fr_good_n, 3);
        chk("ovs_bad", fr_bad_n, 1);

        // ---- asynchronous reset mid-stream ----
        nf_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            nf_in_valid = 1;
            nf_in_data  = 16'(500 + i);
            step();
        end
        nf_in_valid = 0;
        fr_out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            fr_in_valid = 1;
            fr_in_data  = 8'(16 + i);
            fr_in_sop   = (i == 0);
            step();
        end
        fr_in_valid = 0; fr_in_sop = 0;
        repeat (3) step();
        chk("pre_rst_vld", nf_out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_nf_vld", nf_out_valid, 0);
        chk("arst_nf_rdy", nf_in_ready, 0);
        chk("arst_fr_rdy", fr_in_ready, 0);
        @(negedge clk);
        nf_q.delete();
        fr_q.delete();
        rst = 1'b1;
        step();
        chk("post_nf_rdy", nf_in_ready, 1);
        chk("post_nf_vld", nf_out_valid, 0);
        nf_out_ready = 1;
        nf_in_valid = 1; nf_in_data = 16'h0777; nf_in_sop = 1; nf_in_eop = 1;
        fr_in_valid = 1; fr_in_data = 8'h99;    fr_in_sop = 1; fr_in_eop = 1;
        step();
        nf_in_valid = 0; nf_in_sop = 0; nf_in_eop = 0;
        fr_in_valid = 0; fr_in_sop = 0; fr_in_eop = 0;
        repeat (15) step();
        chk("post_nf_cnt", nf_q.size(), 1);
        if (nf_q.size() > 0) begin
            w = nf_q.pop_front();
            chk("post_nf_beat", w, nf_pack(16'h0777, 0, 1, 1, 0, 0));
        end
        chk("post_fr_cnt", fr_q.size(), 1);
        if (fr_q.size() > 0) begin
            w = fr_q.pop_front();
            chk("post_fr_beat", w, fr_pack(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99));
        end
        chk("post_fr_good", fr_good_n, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
